// File: rtl/pwm_hbridge.sv
// H-bridge PWM driver: signed control effort becomes a clamped magnitude and a
// direction, applied only at period boundaries, with dead time on reversal.
module pwm_hbridge #(
  parameter int PERIOD   = 2047,
  parameter int DUTY_MAX = 1946,
  parameter int DEADTIME = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sample_tick,
  input  logic signed [11:0] u_in,
  output logic               pwm_a,
  output logic               pwm_b,
  output logic               dir,
  output logic               sat,
  output logic               period_start
);

  localparam logic [10:0] CNT_TOP  = 11'(PERIOD);
  localparam logic [10:0] DUTY_TOP = 11'(DUTY_MAX);
  localparam logic [10:0] DEAD_LEN = 11'(DEADTIME);

  typedef enum logic [1:0] {OFF, FWD, REV, DEAD} state_t;

  state_t      state, state_nxt;
  logic [10:0] cnt;
  logic [10:0] dead_cnt, dead_nxt;
  logic [10:0] pend_duty, duty_act;
  logic        pend_dir, dir_req;
  logic        dir_nxt;
  logic        wrap;
  logic [11:0] u_bits, abs_val;
  logic [10:0] samp_mag;
  logic        samp_dir, samp_sat;
  logic [10:0] new_duty;
  logic        new_dir, tgt_dir;
  logic        raw, a_nxt, b_nxt;

  assign wrap         = (cnt == CNT_TOP);
  assign period_start = rst && (cnt == '0);
  assign u_bits       = u_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + 11'd1;
  end

  // -2048 has no positive twin in 12 bits, so it folds onto 2047 before clamping
  always_comb begin
    abs_val = u_bits[11] ? (~u_bits + 12'd1) : u_bits;
    if (abs_val == 12'h800) abs_val = 12'h7FF;
    samp_dir = u_bits[11];
    samp_sat = 1'b0;
    samp_mag = abs_val[10:0];
    if (abs_val > {1'b0, DUTY_TOP}) begin
      samp_mag = DUTY_TOP;
      samp_sat = 1'b1;
    end
  end

  assign new_duty = sample_tick ? samp_mag : pend_duty;
  assign new_dir  = sample_tick ? samp_dir : pend_dir;
  assign tgt_dir  = wrap ? new_dir : dir_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_duty <= '0;
      pend_dir  <= 1'b0;
      sat       <= 1'b0;
      duty_act  <= '0;
      dir_req   <= 1'b0;
    end else begin
      if (sample_tick) begin
        pend_duty <= samp_mag;
        pend_dir  <= samp_dir;
        sat       <= samp_sat;
      end
      if (wrap) begin
        duty_act <= new_duty;
        dir_req  <= new_dir;
      end
    end
  end

  // Direction only changes at a boundary or when a dead-time window expires
  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    dir_nxt   = dir;
    if (!en) begin
      state_nxt = OFF;
      dead_nxt  = '0;
    end else begin
      if (state == DEAD) begin
        if (dead_cnt > 11'd1) begin
          dead_nxt = dead_cnt - 11'd1;
        end else begin
          dead_nxt  = '0;
          state_nxt = tgt_dir ? REV : FWD;
          dir_nxt   = tgt_dir;
        end
      end
      if (wrap) begin
        if (new_duty == '0) begin
          state_nxt = OFF;
          dead_nxt  = '0;
        end else if (state == OFF) begin
          state_nxt = new_dir ? REV : FWD;
          dir_nxt   = new_dir;
        end else if ((state != DEAD) && (new_dir != (state == REV))) begin
          if (DEAD_LEN == '0) begin
            state_nxt = new_dir ? REV : FWD;
            dir_nxt   = new_dir;
          end else begin
            state_nxt = DEAD;
            dead_nxt  = DEAD_LEN;
          end
        end
      end
    end
  end

  assign raw   = (cnt < duty_act);
  assign a_nxt = en && (state == FWD) && raw;
  assign b_nxt = en && (state == REV) && raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= OFF;
      dead_cnt <= '0;
      dir      <= 1'b0;
      pwm_a    <= 1'b0;
      pwm_b    <= 1'b0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
      dir      <= dir_nxt;
      pwm_a    <= a_nxt;
      pwm_b    <= b_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_hbridge.sv
// Self-checking bench for pwm_hbridge: directed scenarios plus random effort
// samples, all compared against a period-level behavioural model.
module tb_pwm_hbridge;

  localparam int PERIOD   = 2047;
  localparam int DUTY_MAX = 1946;
  localparam int DEADTIME = 8;
  localparam int NCYC     = PERIOD + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               sample_tick = 1'b0;
  logic signed [11:0] u_in = '0;
  logic               pwm_a, pwm_b, dir, sat, period_start;

  always #5 clk = ~clk;

  pwm_hbridge #(.PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX), .DEADTIME(DEADTIME)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick), .u_in(u_in),
    .pwm_a(pwm_a), .pwm_b(pwm_b), .dir(dir), .sat(sat), .period_start(period_start)
  );

  int compared = 0;
  int mismatched = 0;

  // Model: position in period, pending/active samples, and a per-period plan
  // (is the bridge engaged, which leg, how many leading cycles are blanked).
  int m_cnt, pend_mag, act_mag, blank;
  bit pend_neg, act_neg, eng_neg, driving, m_dir, m_sat, exp_a, exp_b;
  bit cur_en;
  int hi_a, hi_b;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_cnt = 0; pend_mag = 0; act_mag = 0; blank = 0;
    pend_neg = 0; act_neg = 0; eng_neg = 0; driving = 0;
    m_dir = 0; m_sat = 0; exp_a = 0; exp_b = 0;
  endfunction

  function automatic void modelClock(input bit e, input bit tick, input int u);
    bit on;
    int mag;
    on = e && driving && (m_cnt >= blank) && (m_cnt < act_mag);
    exp_a = on && !eng_neg;
    exp_b = on && eng_neg;
    if (e && driving && blank > 0 && m_cnt == blank - 1) m_dir = eng_neg;
    if (!e) driving = 0;
    if (tick) begin
      mag = (u < 0) ? -u : u;
      if (mag > 2047) mag = 2047;
      m_sat = (mag > DUTY_MAX);
      if (mag > DUTY_MAX) mag = DUTY_MAX;
      pend_mag = mag;
      pend_neg = (u < 0);
    end
    if (m_cnt == PERIOD) begin
      act_mag = pend_mag;
      act_neg = pend_neg;
      if (!e || act_mag == 0) driving = 0;
      else if (!driving) begin
        driving = 1; eng_neg = act_neg; blank = 0; m_dir = act_neg;
      end else if (act_neg != eng_neg) begin
        eng_neg = act_neg; blank = DEADTIME;
      end else blank = 0;
    end
    m_cnt = (m_cnt + 1) % NCYC;
  endfunction

  // Drive one cycle of inputs just after a falling edge, then check at the next one
  task automatic applyStimulus(input bit e, input bit tick, input int u);
    en = e;
    sample_tick = tick;
    u_in = 12'(u);
    @(posedge clk);
    modelClock(e, tick, u);
    @(negedge clk);
    sample_tick = 1'b0;
    checkOutput("pwm_a", pwm_a, exp_a);
    checkOutput("pwm_b", pwm_b, exp_b);
    checkOutput("dir", dir, m_dir);
    checkOutput("sat", sat, m_sat);
    checkOutput("period_start", period_start, (m_cnt == 0));
    checkOutput("legs_exclusive", pwm_a & pwm_b, 0);
    hi_a += pwm_a;
    hi_b += pwm_b;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(cur_en, 1'b0, 0);
  endtask

  task automatic tickAt(input int u);
    applyStimulus(cur_en, 1'b1, u);
  endtask

  task automatic toCnt(input int target);
    int guard;
    guard = 0;
    while (m_cnt != target && guard < 2 * NCYC) begin
      idle(1);
      guard++;
    end
    if (m_cnt != target) checkOutput("to_cnt_timeout", m_cnt, target);
  endtask

  task automatic nextBoundary();
    idle(1);
    toCnt(0);
  endtask

  task automatic measurePeriod();
    hi_a = 0;
    hi_b = 0;
    idle(NCYC);
  endtask

  task automatic resetPulse(input string tag);
    #2 rst = 1'b0;
    #1;
    checkOutput({tag, "_a"}, pwm_a, 0);
    checkOutput({tag, "_b"}, pwm_b, 0);
    checkOutput({tag, "_dir"}, dir, 0);
    checkOutput({tag, "_sat"}, sat, 0);
    checkOutput({tag, "_ps"}, period_start, 0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_rel_ps"}, period_start, 1);
    checkOutput({tag, "_rel_a"}, pwm_a, 0);
    checkOutput({tag, "_rel_b"}, pwm_b, 0);
  endtask

  initial begin
    int u, r;
    cur_en = 1'b1;
    hi_a = 0;
    hi_b = 0;
    modelReset();
    @(negedge clk);
    resetPulse("por");

    // Forward 512, ticked mid-period
    idle(300);
    tickAt(512);
    nextBoundary();
    measurePeriod();
    checkOutput("fwd512_hi_a", hi_a, 512);
    checkOutput("fwd512_hi_b", hi_b, 0);
    checkOutput("fwd512_dir", dir, 0);
    checkOutput("fwd512_sat", sat, 0);

    // Sample on the last cycle of a period is used immediately
    toCnt(PERIOD);
    tickAt(100);
    measurePeriod();
    checkOutput("edge_tick_hi_a", hi_a, 100);

    // Full-scale negative and positive clamp
    idle(500);
    tickAt(-2048);
    nextBoundary();
    nextBoundary();
    measurePeriod();
    checkOutput("neg_clamp_hi_b", hi_b, DUTY_MAX);
    checkOutput("neg_clamp_hi_a", hi_a, 0);
    checkOutput("neg_clamp_dir", dir, 1);
    checkOutput("neg_clamp_sat", sat, 1);
    idle(500);
    tickAt(2047);
    nextBoundary();
    nextBoundary();
    measurePeriod();
    checkOutput("pos_clamp_hi_a", hi_a, DUTY_MAX);
    checkOutput("pos_clamp_dir", dir, 0);
    checkOutput("pos_clamp_sat", sat, 1);

    // Reversal from forward 1000 to reverse 300 with dead time
    idle(500);
    tickAt(1000);
    nextBoundary();
    idle(500);
    tickAt(-300);
    nextBoundary();
    hi_a = 0;
    hi_b = 0;
    idle(7);
    checkOutput("rev_dir_c7", dir, 0);
    checkOutput("rev_b_c7", pwm_b, 0);
    idle(1);
    checkOutput("rev_dir_c8", dir, 1);
    checkOutput("rev_b_c8", pwm_b, 0);
    idle(1);
    checkOutput("rev_b_c9", pwm_b, 1);
    idle(NCYC - 9);
    checkOutput("rev_hi_b", hi_b, 300 - DEADTIME);
    checkOutput("rev_hi_a", hi_a, 0);
    checkOutput("rev_sat", sat, 0);

    // Enable dropped mid-pulse, direction changed while disabled
    toCnt(100);
    checkOutput("en_pre_b", pwm_b, 1);
    cur_en = 1'b0;
    idle(1);
    checkOutput("en_off_b", pwm_b, 0);
    idle(200);
    tickAt(400);
    idle(100);
    cur_en = 1'b1;
    idle(50);
    checkOutput("en_wait_a", pwm_a, 0);
    checkOutput("en_wait_b", pwm_b, 0);
    nextBoundary();
    checkOutput("en_back_dir", dir, 0);
    idle(1);
    checkOutput("en_back_a", pwm_a, 1);

    // Reset during dead time, then during a high pulse
    idle(300);
    tickAt(-600);
    nextBoundary();
    idle(3);
    resetPulse("rst_dead");
    idle(100);
    tickAt(700);
    nextBoundary();
    toCnt(50);
    checkOutput("rst_pulse_pre_a", pwm_a, 1);
    resetPulse("rst_pulse");

    // Random effort samples, enable toggles and occasional resets
    repeat (20000) begin
      r = $urandom_range(0, 999);
      case ($urandom_range(0, 3))
        0: u = int'($urandom_range(0, 4095)) - 2048;
        1: u = 0;
        2: u = int'($urandom_range(1900, 2047)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
        default: u = int'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
      endcase
      if ($urandom_range(0, 2999) == 0) cur_en = !cur_en;
      if ($urandom_range(0, 14999) == 0) resetPulse("rnd_rst");
      applyStimulus(cur_en, (r < 3), u);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
